// File: rtl/line_buf_sched_pkg.sv
// Shared types and index helpers for the line-buffer ring scheduler.
// Helpers work at the maximum ring size; callers cast results to their own width.
package line_buf_pkg;

    localparam int unsigned MaxWin  = 8;
    localparam int unsigned MaxIdxW = 3;

    typedef enum logic [2:0] {
        StFill,
        StArm,
        StRead,
        StFlush,
        StWaitLine
    } sched_state_t;

    // Explicit wrap so non-power-of-2 ring sizes never reach an illegal index.
    function automatic logic [MaxIdxW-1:0] idx_inc(input logic [MaxIdxW-1:0] idx,
                                                   input int unsigned win);
        if (32'(idx) == win - 32'd1) begin
            return '0;
        end
        return idx + MaxIdxW'(1);
    endfunction

    function automatic logic [MaxWin-1:0] idx_to_onehot(input logic [MaxIdxW-1:0] idx);
        logic [MaxWin-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/line_buf_sched_if.sv
// Control bundle between the scheduler (master) and the line-buffer ring (slave).
interface line_buf_sched_if #(
    parameter int unsigned WIN_SIZE  = 3,
    parameter int unsigned IDX_WIDTH = $clog2(WIN_SIZE),
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 sof_i;
    logic                 eol_i;
    logic                 out_eol_i;
    logic [WIN_SIZE-1:0]  empty_i;
    logic [WIN_SIZE-1:0]  unread_i;
    logic [WIN_SIZE-1:0]  wr_sel_o;
    logic [WIN_SIZE-1:0]  pop_line_o;
    logic [WIN_SIZE-1:0]  flush_line_o;
    logic [IDX_WIDTH-1:0] oldest_idx_o;
    logic                 win_active_o;
    logic [CNT_WIDTH-1:0] line_cnt_o;

    modport master (
        input  sof_i, eol_i, out_eol_i, empty_i, unread_i,
        output wr_sel_o, pop_line_o, flush_line_o, oldest_idx_o, win_active_o, line_cnt_o
    );

    modport slave (
        output sof_i, eol_i, out_eol_i, empty_i, unread_i,
        input  wr_sel_o, pop_line_o, flush_line_o, oldest_idx_o, win_active_o, line_cnt_o
    );

endinterface

// File: rtl/line_buf_sched.sv
// Sequences a ring of line buffers into a sliding vertical window: fill, pop all
// together, flush the oldest row, refill it with the next line.
module line_buf_sched
    import line_buf_pkg::*;
#(
    parameter int unsigned WIN_SIZE  = 3,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    line_buf_sched_if.master  bus
);

    localparam int unsigned IDX_WIDTH = $clog2(WIN_SIZE);
    localparam int unsigned FILL_W    = IDX_WIDTH + 1;
    localparam logic [FILL_W-1:0] FillLast = FILL_W'(WIN_SIZE - 1);

    sched_state_t         state_q, state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [WIN_SIZE-1:0]  wr_sel_q, wr_sel_d;
    logic [WIN_SIZE-1:0]  pop_q, pop_d;
    logic [WIN_SIZE-1:0]  flush_q, flush_d;
    logic [IDX_WIDTH-1:0] oldest_q, oldest_d;
    logic                 win_active_q, win_active_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [IDX_WIDTH-1:0] newest;

    // Newest row sits just behind the oldest in the ring.
    always_comb begin
        if (oldest_q == '0) begin
            newest = IDX_WIDTH'(WIN_SIZE - 1);
        end else begin
            newest = oldest_q - IDX_WIDTH'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        wr_sel_d     = wr_sel_q;
        pop_d        = '0;
        flush_d      = '0;
        oldest_d     = oldest_q;
        win_active_d = win_active_q;
        line_cnt_d   = line_cnt_q;

        if (bus.sof_i) begin
            state_d      = StFill;
            oldest_d     = '0;
            line_cnt_d   = '0;
            win_active_d = 1'b0;
            if (bus.eol_i) begin
                fill_cnt_d = FILL_W'(1);
                wr_sel_d   = WIN_SIZE'(idx_to_onehot(MaxIdxW'(1)));
            end else begin
                fill_cnt_d = '0;
                wr_sel_d   = WIN_SIZE'(idx_to_onehot('0));
            end
        end else begin
            unique case (state_q)
                StFill: begin
                    if (bus.eol_i) begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                        if (fill_cnt_q == FillLast) begin
                            wr_sel_d = '0;
                            state_d  = StArm;
                        end else begin
                            wr_sel_d = {wr_sel_q[WIN_SIZE-2:0], wr_sel_q[WIN_SIZE-1]};
                        end
                    end
                end
                StArm: begin
                    // Waiting on the flags covers the buffers' one-cycle lag after tlast.
                    if (bus.empty_i == '0 && bus.unread_i[newest]) begin
                        pop_d        = '1;
                        win_active_d = 1'b1;
                        state_d      = StRead;
                    end
                end
                StRead: begin
                    if (bus.out_eol_i) begin
                        win_active_d = 1'b0;
                        line_cnt_d   = line_cnt_q + CNT_WIDTH'(1);
                        flush_d      = WIN_SIZE'(idx_to_onehot(MaxIdxW'(oldest_q)));
                        state_d      = StFlush;
                    end
                end
                StFlush: begin
                    wr_sel_d = WIN_SIZE'(idx_to_onehot(MaxIdxW'(oldest_q)));
                    oldest_d = IDX_WIDTH'(idx_inc(MaxIdxW'(oldest_q), WIN_SIZE));
                    state_d  = StWaitLine;
                end
                StWaitLine: begin
                    if (bus.eol_i) begin
                        wr_sel_d = '0;
                        state_d  = StArm;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StFill;
            fill_cnt_q   <= '0;
            wr_sel_q     <= WIN_SIZE'(1);
            pop_q        <= '0;
            flush_q      <= '0;
            oldest_q     <= '0;
            win_active_q <= 1'b0;
            line_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            wr_sel_q     <= wr_sel_d;
            pop_q        <= pop_d;
            flush_q      <= flush_d;
            oldest_q     <= oldest_d;
            win_active_q <= win_active_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

    assign bus.wr_sel_o     = wr_sel_q;
    assign bus.pop_line_o   = pop_q;
    assign bus.flush_line_o = flush_q;
    assign bus.oldest_idx_o = oldest_q;
    assign bus.win_active_o = win_active_q;
    assign bus.line_cnt_o   = line_cnt_q;

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed bench: vector table on a 3-row ring, plus stall, async reset and 5-row wrap.
module tb_line_buf_sched;

    typedef struct {
        logic        sof;
        logic        eol;
        logic        oeol;
        logic [2:0]  empty;
        logic [2:0]  unread;
        logic [2:0]  wr;
        logic [2:0]  pop;
        logic [2:0]  fl;
        logic [1:0]  old;
        logic        act;
        logic [15:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    line_buf_sched_if #(.WIN_SIZE(3), .CNT_WIDTH(16)) b3 ();
    line_buf_sched_if #(.WIN_SIZE(5), .CNT_WIDTH(16)) b5 ();

    line_buf_sched #(.WIN_SIZE(3), .CNT_WIDTH(16)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b3)
    );

    line_buf_sched #(.WIN_SIZE(5), .CNT_WIDTH(16)) u_dut5 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic sof, input logic eol, input logic oeol,
                                input logic [2:0] empty, input logic [2:0] unread,
                                input logic [2:0] wr, input logic [2:0] pop,
                                input logic [2:0] fl, input logic [1:0] old,
                                input logic act, input logic [15:0] cnt);
        vec_t v;
        v.sof = sof; v.eol = eol; v.oeol = oeol; v.empty = empty; v.unread = unread;
        v.wr = wr; v.pop = pop; v.fl = fl; v.old = old; v.act = act; v.cnt = cnt;
        return v;
    endfunction

    // {wr_sel, pop, flush, oldest, active, count} of the 3-row instance.
    function automatic logic [63:0] out3();
        return 64'({b3.wr_sel_o, b3.pop_line_o, b3.flush_line_o, b3.oldest_idx_o,
                    b3.win_active_o, b3.line_cnt_o});
    endfunction

    function automatic logic [63:0] exp3(input vec_t v);
        return 64'({v.wr, v.pop, v.fl, v.old, v.act, v.cnt});
    endfunction

    initial begin
        logic       got;
        logic [2:0] exp_old;
        logic [2:0] nxt;

        //             sof eol oe empty   unread  wr      pop     flush  old act cnt
        vecs.push_back(mk(1, 0, 0, 3'b111, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3'b111, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b111, 3'b001, 3'b000, 3'b000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 3'b000, 3'b111, 3'b001, 3'b000, 3'b000, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b111, 3'b000, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 2, 0, 2));
        vecs.push_back(mk(0, 1, 0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2, 0, 2));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b010, 3'b000, 3'b111, 3'b000, 2, 1, 2));
        vecs.push_back(mk(0, 0, 1, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 2, 0, 3));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b111, 3'b000, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 1, 0, 4));
        vecs.push_back(mk(0, 1, 0, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b111, 3'b000, 1, 1, 4));
        vecs.push_back(mk(1, 0, 0, 3'b111, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b111, 3'b000, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0));

        rst = 1'b1;
        b3.sof_i = 0; b3.eol_i = 0; b3.out_eol_i = 0; b3.empty_i = '1; b3.unread_i = '0;
        b5.sof_i = 0; b5.eol_i = 0; b5.out_eol_i = 0; b5.empty_i = '1; b5.unread_i = '0;
        #3;
        check("reset_values", out3(), 64'({3'b001, 3'b000, 3'b000, 2'd0, 1'b0, 16'd0}));
        step();
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            b3.sof_i     = vecs[i].sof;
            b3.eol_i     = vecs[i].eol;
            b3.out_eol_i = vecs[i].oeol;
            b3.empty_i   = vecs[i].empty;
            b3.unread_i  = vecs[i].unread;
            step();
            check($sformatf("vec%0d", i), out3(), exp3(vecs[i]));
        end

        // Newest is buffer 2 here; hold its unread flag low.
        b3.sof_i = 0; b3.eol_i = 0; b3.out_eol_i = 0;
        b3.empty_i = 3'b000; b3.unread_i = 3'b011;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("arm_stall%0d", c), 64'(b3.pop_line_o), 64'h0);
        end
        b3.unread_i = 3'b111;
        step();
        check("arm_release_pop", 64'(b3.pop_line_o), 64'h7);
        b3.out_eol_i = 1;
        step();
        b3.out_eol_i = 0;
        check("post_stall_flush", out3(), 64'({3'b000, 3'b000, 3'b001, 2'd0, 1'b0, 16'd1}));
        step();
        check("wait_line_state", out3(), 64'({3'b001, 3'b000, 3'b000, 2'd1, 1'b0, 16'd1}));

        // Reset lands mid-cycle; outputs must clear before any edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", out3(), 64'({3'b001, 3'b000, 3'b000, 2'd0, 1'b0, 16'd0}));
        #2;
        rst = 1'b0;
        step();

        // Five-row ring: oldest must walk 0..4 and wrap to 0.
        b5.empty_i = '0; b5.unread_i = '1;
        b5.sof_i = 1;
        step();
        b5.sof_i = 0;
        check("w5_sof_wr", 64'(b5.wr_sel_o), 64'h01);
        for (int l = 0; l < 5; l++) begin
            b5.eol_i = 1;
            step();
            b5.eol_i = 0;
        end
        check("w5_fill_wr", 64'(b5.wr_sel_o), 64'h00);
        exp_old = 3'd0;
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            for (int c = 0; c < 5 && !got; c++) begin
                step();
                if (b5.pop_line_o == 5'h1f) got = 1'b1;
            end
            check($sformatf("w5_pop%0d", k), 64'(got), 64'h1);
            check($sformatf("w5_old_at_pop%0d", k), 64'(b5.oldest_idx_o), 64'(exp_old));
            b5.out_eol_i = 1;
            step();
            b5.out_eol_i = 0;
            check($sformatf("w5_flush%0d", k), 64'(b5.flush_line_o), 64'(5'b00001 << exp_old));
            step();
            nxt = (exp_old == 3'd4) ? 3'd0 : exp_old + 3'd1;
            check($sformatf("w5_old_next%0d", k), 64'(b5.oldest_idx_o), 64'(nxt));
            check($sformatf("w5_wr%0d", k), 64'(b5.wr_sel_o), 64'(5'b00001 << exp_old));
            exp_old = nxt;
            b5.eol_i = 1;
            step();
            b5.eol_i = 0;
        end
        check("w5_line_cnt", 64'(b5.line_cnt_o), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
